// File: rtl/dpcd_init.sv
// dpcd_init: reads the DPCD receiver capabilities, then writes LINK_BW_SET/LANE_COUNT_SET with retries.
// Define DPCD_VERIFY_EN to read back and compare every write.
module dpcd_init #(
  parameter int NCAP = 16,
  parameter int RETRIES = 7,
  parameter int GAPCYC = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        fail,
  input  logic [3:0]  capaddr,
  output logic [7:0]  capdata,
  output logic [7:0]  linkbw,
  output logic [7:0]  lanes,
  output logic [19:0] auxaddr,
  output logic [7:0]  auxwdata,
  output logic        auxreq,
  output logic        auxwr,
  input  logic        auxack,
  input  logic        auxerr,
  input  logic [7:0]  auxrdata
);
`ifdef DPCD_VERIFY_EN
  localparam int NT = NCAP + 4;
`else
  localparam int NT = NCAP + 2;
`endif
  localparam logic [4:0] NC = 5'(NCAP);
  localparam logic [4:0] LAST = 5'(NT - 1);
  localparam logic [2:0] RMAX = 3'(RETRIES);
  localparam logic [15:0] GLAST = 16'(GAPCYC - 1);
  typedef enum logic [2:0] {IDLE, REQ, GAP, NEXT, DONE, FAIL} state_t;
  state_t state, state_n;
  logic [4:0] i, i_n;
  logic [2:0] r, r_n;
  logic [15:0] gcnt;
  logic [7:0] cap [16];
  logic [19:0] t_addr;
  logic t_wr;
  logic [7:0] t_data, bw_v, lanes_v;
  logic [4:0] l_raw;
  logic rb, bad;
  assign auxreq = state == REQ;
  assign busy = state == REQ || state == GAP || state == NEXT;
  assign done = state == DONE;
  assign capdata = cap[capaddr];
  assign rb = !auxwr && i >= NC;
  // a readback that disagrees with the written value is treated like an AUX error
  assign bad = auxerr || (rb && auxrdata != auxwdata);
  assign l_raw = cap[2][4:0];
  assign bw_v = (cap[1] == 8'h06 || cap[1] == 8'h0A || cap[1] == 8'h14) ? cap[1] : 8'h06;
  assign lanes_v = {cap[2][7], 2'b00, (l_raw == 5'd1 || l_raw == 5'd2 || l_raw == 5'd4) ? l_raw : 5'd1};
  always_comb begin
`ifdef DPCD_VERIFY_EN
    t_addr = i_n < NC ? {15'd0, i_n} : (i_n < NC + 5'd2 ? 20'h00100 : 20'h00101);
    t_wr = i_n == NC || i_n == NC + 5'd2;
`else
    t_addr = i_n < NC ? {15'd0, i_n} : (i_n == NC ? 20'h00100 : 20'h00101);
    t_wr = i_n >= NC;
`endif
    t_data = i_n < NC ? 8'd0 : (t_addr[0] ? lanes : linkbw);
  end
  always_comb begin
    state_n = state;
    i_n = i;
    r_n = r;
    case (state)
      IDLE: if (start) begin
        state_n = REQ;
        i_n = '0;
        r_n = '0;
      end
      REQ: if (auxack) begin
        if (!bad) state_n = NEXT;
        else if (r < RMAX) begin
          state_n = GAP;
          r_n = r + 3'd1;
          i_n = rb ? i - 5'd1 : i;
        end else state_n = FAIL;
      end
      GAP: if (gcnt == GLAST) state_n = REQ;
      NEXT: begin
        i_n = i + 5'd1;
`ifdef DPCD_VERIFY_EN
        r_n = auxwr ? r : 3'd0;
`else
        r_n = 3'd0;
`endif
        state_n = i == LAST ? DONE : REQ;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i <= '0;
      r <= '0;
      gcnt <= '0;
      fail <= 1'b0;
      auxaddr <= '0;
      auxwdata <= '0;
      auxwr <= 1'b0;
      linkbw <= '0;
      lanes <= '0;
      for (int k = 0; k < 16; k++) cap[k] <= '0;
    end else begin
      state <= state_n;
      i <= i_n;
      r <= r_n;
      gcnt <= state == GAP ? gcnt + 16'd1 : '0;
      fail <= (state == IDLE && start) ? 1'b0 : (state_n == FAIL ? 1'b1 : fail);
      if (state_n == REQ && state != REQ) begin
        auxaddr <= t_addr;
        auxwdata <= t_data;
        auxwr <= t_wr;
      end
      if (state == REQ && auxack && !auxerr && !auxwr && i < NC) cap[i[3:0]] <= auxrdata;
      if (state == NEXT && i == 5'd1) linkbw <= bw_v;
      if (state == NEXT && i == 5'd2) lanes <= lanes_v;
    end
  end
endmodule

// File: tb/tb_dpcd_init.sv
// tb_dpcd_init: randomized AUX responder plus transaction-list reference model for dpcd_init.
module tb_dpcd_init;
  localparam int NCAP = 16;
  localparam int RETRIES = 7;
  localparam int GAPCYC = 4000;
`ifdef DPCD_VERIFY_EN
  localparam int NT = NCAP + 4;
`else
  localparam int NT = NCAP + 2;
`endif
  logic clk = 0, reset = 1, start = 0;
  logic [3:0] capaddr = 0;
  logic busy, done, fail, auxreq, auxwr;
  logic [7:0] capdata, linkbw, lanes, auxwdata;
  logic [19:0] auxaddr;
  logic auxack = 0, auxerr = 0;
  logic [7:0] auxrdata = 0;
  always #5 clk = ~clk;
  dpcd_init dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
    .capaddr(capaddr), .capdata(capdata), .linkbw(linkbw), .lanes(lanes),
    .auxaddr(auxaddr), .auxwdata(auxwdata), .auxreq(auxreq), .auxwr(auxwr),
    .auxack(auxack), .auxerr(auxerr), .auxrdata(auxrdata)
  );
  typedef struct {int addr; bit wr; logic [7:0] data; bit bad; int idle;} att_t;
  att_t log_q[$];
  att_t succ[$];
  int exp_addr[$];
  bit exp_wr[$];
  logic [7:0] exp_data[$];
  logic [7:0] mem [16];
  logic [7:0] wmem [2];
  int lat = 0, err_addr = -1, err_limit = 0, err_taken = 0, cor_limit = 0, cor_taken = 0;
  int late_req = 0, late_seen = 0, cyc = 0, last_ack = 0, wcnt = 0, rise_idle = 0, done_cnt = 0;
  bit rsp_en = 1;
  bit r_e, r_c;
  logic [7:0] r_d;
  int checks = 0, errors = 0;

  // AUX engine model: acks after lat cycles, injects errors/corrupted readbacks on request
  initial forever begin
    @(negedge clk);
    cyc++;
    if (done) done_cnt++;
    auxack = 0;
    auxerr = 0;
    if (late_req != late_seen) begin
      late_seen = late_req;
      auxack = 1;
      auxrdata = 8'h5A;
    end else if (auxreq && rsp_en) begin
      if (wcnt == 0) rise_idle = cyc - last_ack - 1;
      if (wcnt >= lat) begin
        r_e = int'(auxaddr) == err_addr && err_taken < err_limit;
        if (r_e) err_taken++;
        r_c = !r_e && !auxwr && auxaddr == 20'h00100 && cor_taken < cor_limit;
        if (r_c) cor_taken++;
        r_d = auxwr ? auxwdata : (auxaddr < 16 ? mem[auxaddr[3:0]] : (r_c ? 8'h00 : wmem[auxaddr[0]]));
        if (auxwr && !r_e) wmem[auxaddr[0]] = auxwdata;
        auxack = 1;
        auxerr = r_e;
        auxrdata = r_d;
        log_q.push_back('{int'(auxaddr), auxwr, r_d, r_e || r_c, rise_idle});
        last_ack = cyc;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  function automatic logic [7:0] exp_bw(input logic [7:0] c);
    return (c == 8'h06 || c == 8'h0A || c == 8'h14) ? c : 8'h06;
  endfunction
  function automatic logic [7:0] exp_lanes(input logic [7:0] c);
    int l = int'(c[4:0]);
    return {c[7], 2'b00, (l == 1 || l == 2 || l == 4) ? c[4:0] : 5'd1};
  endfunction
  function automatic void build_exp();
    exp_addr.delete(); exp_wr.delete(); exp_data.delete();
    for (int a = 0; a < NCAP; a++) begin
      exp_addr.push_back(a); exp_wr.push_back(0); exp_data.push_back(mem[a]);
    end
    exp_addr.push_back('h100); exp_wr.push_back(1); exp_data.push_back(exp_bw(mem[1]));
`ifdef DPCD_VERIFY_EN
    exp_addr.push_back('h100); exp_wr.push_back(0); exp_data.push_back(exp_bw(mem[1]));
`endif
    exp_addr.push_back('h101); exp_wr.push_back(1); exp_data.push_back(exp_lanes(mem[2]));
`ifdef DPCD_VERIFY_EN
    exp_addr.push_back('h101); exp_wr.push_back(0); exp_data.push_back(exp_lanes(mem[2]));
`endif
  endfunction
  function automatic void collect(input int base);
    succ.delete();
    for (int k = base; k < log_q.size(); k++) if (!log_q[k].bad) succ.push_back(log_q[k]);
  endfunction
  function automatic void rand_mem();
    for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
  endfunction

  task automatic go(input int budget);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int k = 0; k < budget && !(done || fail); k++) @(negedge clk);
    checks++;
    if (!(done || fail)) begin
      errors++;
      $display("FAIL timeout: no done/fail within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, fail, auxreq, auxwr} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, fail, auxreq, auxwr});
    end
    checks++;
    if ({auxaddr, auxwdata, linkbw, lanes} !== 44'h0) begin
      errors++; $display("FAIL reset_regs got %h/%h/%h/%h want 0", auxaddr, auxwdata, linkbw, lanes);
    end
    for (int a = 0; a < 16; a++) begin
      capaddr = 4'(a); #1;
      checks++;
      if (capdata !== 8'h00) begin errors++; $display("FAIL reset_cap%0d got %h want 00", a, capdata); end
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int base = log_q.size(), d0 = done_cnt;
    for (int a = 0; a < 16; a++) mem[a] = 8'(a) ^ 8'hA5;
    mem[1] = 8'h0A; mem[2] = 8'h84; lat = 10;
    go(2000);
    build_exp(); collect(base);
    checks++;
    if (succ.size() != NT) begin errors++; $display("FAIL basic_count got %0d want %0d", succ.size(), NT); end
    for (int k = 0; k < succ.size() && k < NT; k++) begin
      checks++;
      if (succ[k].addr != exp_addr[k] || succ[k].wr != exp_wr[k] || succ[k].data !== exp_data[k]) begin
        errors++;
        $display("FAIL basic_txn%0d got %h/%0b/%h want %h/%0b/%h", k, succ[k].addr, succ[k].wr, succ[k].data,
                 exp_addr[k], exp_wr[k], exp_data[k]);
      end
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done got %0d pulses want 1", done_cnt - d0); end
    capaddr = 3; #1;
    checks++;
    if (capdata !== 8'hA6) begin errors++; $display("FAIL basic_cap3 got %h want a6", capdata); end
    checks++;
    if ({linkbw, lanes, busy} !== {8'h0A, 8'h84, 1'b0}) begin
      errors++; $display("FAIL basic_link got %h/%h/%b want 0a/84/0", linkbw, lanes, busy);
    end
  endtask

  task automatic test_map();
    rand_mem(); mem[1] = 8'h1B; mem[2] = 8'h03; lat = int'($urandom_range(0, 4));
    go(2000);
    checks++;
    if (linkbw !== exp_bw(mem[1])) begin errors++; $display("FAIL map_bw got %h want %h", linkbw, exp_bw(mem[1])); end
    checks++;
    if (lanes !== exp_lanes(mem[2])) begin errors++; $display("FAIL map_lanes got %h want %h", lanes, exp_lanes(mem[2])); end
  endtask

  task automatic test_random();
    repeat (4) begin
      int base = log_q.size(), d0 = done_cnt;
      rand_mem();
      case ($urandom % 4)
        0: mem[1] = 8'h06;
        1: mem[1] = 8'h0A;
        2: mem[1] = 8'h14;
        default: ;
      endcase
      case ($urandom % 4)
        0: mem[2][4:0] = 5'd1;
        1: mem[2][4:0] = 5'd2;
        2: mem[2][4:0] = 5'd4;
        default: ;
      endcase
      lat = int'($urandom_range(0, 6));
      go(3000);
      build_exp(); collect(base);
      checks++;
      if (succ.size() != NT) begin errors++; $display("FAIL rand_count got %0d want %0d", succ.size(), NT); end
      for (int k = 0; k < succ.size() && k < NT; k++) begin
        checks++;
        if (succ[k].addr != exp_addr[k] || succ[k].wr != exp_wr[k] || succ[k].data !== exp_data[k]) begin
          errors++;
          $display("FAIL rand_txn%0d got %h/%0b/%h want %h/%0b/%h", k, succ[k].addr, succ[k].wr, succ[k].data,
                   exp_addr[k], exp_wr[k], exp_data[k]);
        end
      end
      for (int a = 0; a < 16; a++) begin
        capaddr = 4'(a); #1;
        checks++;
        if (capdata !== mem[a]) begin errors++; $display("FAIL rand_cap%0d got %h want %h", a, capdata, mem[a]); end
      end
      checks++;
      if ({linkbw, lanes} !== {exp_bw(mem[1]), exp_lanes(mem[2])}) begin
        errors++; $display("FAIL rand_link got %h/%h want %h/%h", linkbw, lanes, exp_bw(mem[1]), exp_lanes(mem[2]));
      end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL rand_done got %0d pulses want 1", done_cnt - d0); end
    end
  endtask

  task automatic test_retry();
    int base = log_q.size(), d0 = done_cnt, n5 = 0;
    rand_mem(); lat = 2; err_addr = 5; err_limit = err_taken + 2;
    go(20000);
    for (int k = base; k < log_q.size(); k++) if (log_q[k].addr == 5) begin
      n5++;
      if (n5 > 1) begin
        checks++;
        if (log_q[k].idle != GAPCYC) begin
          errors++; $display("FAIL retry_gap got %0d idle cycles want %0d", log_q[k].idle, GAPCYC);
        end
      end
    end
    checks++;
    if (n5 != 3) begin errors++; $display("FAIL retry_attempts got %0d want 3", n5); end
    collect(base);
    checks++;
    if (succ.size() != NT || done_cnt - d0 != 1) begin
      errors++; $display("FAIL retry_done got %0d txns/%0d pulses want %0d/1", succ.size(), done_cnt - d0, NT);
    end
  endtask

  task automatic test_fail();
    int base = log_q.size(), d0 = done_cnt, n0 = 0;
    rand_mem(); lat = 1; err_addr = 0; err_limit = err_taken + 1000;
    go(40000);
    for (int k = base; k < log_q.size(); k++) if (log_q[k].addr == 0) n0++;
    checks++;
    if (n0 != RETRIES + 1) begin errors++; $display("FAIL fail_attempts got %0d want %0d", n0, RETRIES + 1); end
    checks++;
    if ({fail, busy} !== 2'b10) begin errors++; $display("FAIL fail_flags got fail=%b busy=%b want 1/0", fail, busy); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL fail_done got %0d pulses want 0", done_cnt - d0); end
    err_limit = err_taken;
    base = log_q.size(); d0 = done_cnt;
    go(3000);
    checks++;
    if (fail !== 1'b0 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL restart got fail=%b pulses=%0d want 0/1", fail, done_cnt - d0);
    end
    checks++;
    if (log_q.size() <= base || log_q[base].addr != 0 || log_q[base].wr) begin
      errors++; $display("FAIL restart_first got %0d entries want first read at 0", log_q.size() - base);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    rsp_en = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    for (int k = 0; k < 20 && !auxreq; k++) @(negedge clk);
    checks++;
    if (auxreq !== 1'b1) begin errors++; $display("FAIL rmid_req got %b want 1", auxreq); end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({auxreq, busy} !== 2'b00) begin errors++; $display("FAIL rmid_drop got req=%b busy=%b want 0/0", auxreq, busy); end
    reset = 0;
    late_req++;
    repeat (3) @(negedge clk);
    capaddr = 0; #1;
    checks++;
    if ({capdata, auxreq, busy} !== 10'h0) begin
      errors++; $display("FAIL rmid_late got cap=%h req=%b busy=%b want 00/0/0", capdata, auxreq, busy);
    end
    rsp_en = 1; lat = 0; d0 = done_cnt;
    go(3000);
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL rmid_idle got %0d pulses want 1", done_cnt - d0); end
  endtask

`ifdef DPCD_VERIFY_EN
  task automatic test_verify();
    int base = log_q.size(), d0 = done_cnt, nw = 0;
    rand_mem(); lat = 3; cor_limit = cor_taken + 1;
    go(10000);
    for (int k = base; k < log_q.size(); k++) if (log_q[k].addr == 'h100 && log_q[k].wr) begin
      nw++;
      if (nw == 2) begin
        checks++;
        if (log_q[k].idle != GAPCYC) begin
          errors++; $display("FAIL verify_gap got %0d want %0d", log_q[k].idle, GAPCYC);
        end
      end
    end
    checks++;
    if (nw != 2) begin errors++; $display("FAIL verify_writes got %0d want 2", nw); end
    build_exp(); collect(base);
    checks++;
    if (succ.size() != NT || done_cnt - d0 != 1) begin
      errors++; $display("FAIL verify_done got %0d txns/%0d pulses want %0d/1", succ.size(), done_cnt - d0, NT);
    end
    for (int k = 0; k < succ.size() && k < NT; k++) begin
      checks++;
      if (succ[k].addr != exp_addr[k] || succ[k].wr != exp_wr[k] || succ[k].data !== exp_data[k]) begin
        errors++; $display("FAIL verify_txn%0d got %h/%0b/%h want %h/%0b/%h", k, succ[k].addr, succ[k].wr,
                           succ[k].data, exp_addr[k], exp_wr[k], exp_data[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_map();
    test_random();
    test_retry();
    test_fail();
    test_reset_mid();
`ifdef DPCD_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dpcd_init.md
Name: dpcd_init

Overview:
- Upstream transaction sequencer for the AUX channel engine.
- On `start`, reads the sink's DPCD receiver-capability block over the engine's req/ack interface and retries failed transactions.
- Then writes the link configuration registers (LINK_BW_SET 0x00100, LANE_COUNT_SET 0x00101) derived from the captured capabilities.
- Exposes the captured bytes and the chosen link settings to the main link logic.

Parameters:
- NCAP, 16, number of capability bytes read starting at DPCD address 0x00000 (legal 3..16).
- RETRIES, 7, maximum retries per transaction after the first attempt.
- GAPCYC, 4000, idle clock cycles between a failed attempt and its retry.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a sequence when idle
- busy  out  1  high from the cycle after an accepted `start` until `done` or `fail`
- done  out  1  one-cycle pulse on successful completion
- fail  out  1  level; set when retries are exhausted, cleared by `start` or `reset`
- capaddr  in  4  capture-buffer read address
- capdata  out  8  captured byte at `capaddr`, combinational read
- linkbw  out  8  value written to 0x00100
- lanes  out  8  value written to 0x00101
- auxaddr  out  20  DPCD address to the AUX engine
- auxwdata  out  8  write data to the AUX engine
- auxreq  out  1  transaction request
- auxwr  out  1  1 = write, 0 = read
- auxack  in  1  one-cycle completion strobe from the AUX engine
- auxerr  in  1  valid with `auxack`; 1 = NACK, DEFER or timeout
- auxrdata  in  8  read data, valid with `auxack`

Behaviour:
- Reset values:
  - `busy`, `done`, `fail`, `auxreq`, `auxwr` = 0.
  - `auxaddr` = 0, `auxwdata` = 0, `linkbw` = 0, `lanes` = 0.
  - Capture buffer cleared to 0.
  - State = IDLE.
- Reset mid-transaction drops `auxreq` in the next cycle. Any `auxack` arriving afterwards is ignored.
- AUX handshake:
  - `auxaddr`, `auxwdata` and `auxwr` are registered and stable from the cycle `auxreq` rises until `auxack` is seen.
  - `auxreq` is held high until a cycle with `auxack` = 1.
  - `auxreq` deasserts the next cycle and stays low for at least 1 cycle before any new request.
  - `auxack` while `auxreq` = 0 is ignored.
- States:
  - IDLE: `start` → REQ with index i = 0, retry count r = 0, `fail` cleared. `start` in any other state is ignored.
  - REQ: `auxreq` = 1, waiting for `auxack`.
    - Ack with `auxerr` = 0 → NEXT. On a read, `auxrdata` is stored to `cap[i]`.
    - Ack with `auxerr` = 1 and r < RETRIES → GAP, r++.
    - Ack with `auxerr` = 1 and r = RETRIES → FAIL.
  - GAP: counts GAPCYC cycles with `auxreq` = 0, then returns to REQ with the same transaction.
  - NEXT: one cycle. r = 0, i++. When i reaches the last transaction → DONE, otherwise → REQ.
  - DONE: pulse `done` for 1 cycle, `busy` = 0, → IDLE.
  - FAIL: `fail` = 1, `busy` = 0, → IDLE. `linkbw`, `lanes` and `cap` keep their partial contents.
- Transaction list:
  - i = 0..NCAP-1: read, address i.
  - i = NCAP: write 0x00100, data `linkbw`.
    - `linkbw` is latched in NEXT after i = 1 completes.
    - `linkbw` = `cap[1]`, except values other than 0x06, 0x0A, 0x14 map to 0x06.
  - i = NCAP+1: write 0x00101, data `lanes`.
    - `lanes` is latched in NEXT after i = 2 completes.
    - `lanes` = {`cap[2][7]`, 2'b00, L}.
    - L = `cap[2][4:0]` if that value is 1, 2 or 4, else 1.
- The retry counter is 3 bits wide, sized for RETRIES ≤ 7. The GAP counter is 16 bits.

Optional Feature:
- Macro: DPCD_VERIFY_EN.
- When defined, each write is followed by a read of the same address. The read data is compared with the written value:
  - Mismatch counts as a failed attempt of the write, which restarts at the write (same retry counter).
  - Total transactions = NCAP + 4.
- When undefined, no readback is performed. Total transactions = NCAP + 2.

Test Plan:
- Reset, then `start`; model acks every request after 10 cycles with data = addr XOR 0xA5, except `cap[1]` = 0x0A and `cap[2]` = 0x84.
  - Required: 16 reads at 0x00..0x0F.
  - Required: write 0x00100 = 0x0A, then write 0x00101 = 0x84.
  - Required: `done` pulses once, `capdata`@3 = 0xA6.
- `cap[1]` = 0x1B, `cap[2]` = 0x03 → `linkbw` = 0x06, `lanes` = 0x01.
- Read of address 5 errors twice, then succeeds → exactly GAPCYC idle cycles before each retry, 3 requests at address 5, `done` asserted.
- Read of address 0 always errors → 8 attempts, `fail` = 1, `done` never pulses, `busy` = 0.
  - A second `start` clears `fail` and restarts at address 0.
- `reset` asserted while `auxreq` = 1 → `auxreq` = 0 next cycle, a late `auxack` causes no capture, state is IDLE.
- With DPCD_VERIFY_EN: readback of 0x00100 returns 0x00 once → write 0x00100 repeated after GAPCYC, 20 transactions total, `done` asserted.
